// File: rtl/single_ch_dcfifo_n2p_pkg.sv
// Shared definitions for the negedge/posedge single-channel FIFO family:
// pointer width derivation and binary-to-Gray conversion.
package single_ch_dcfifo_n2p_pkg;

    localparam int PTR_MAX_W = 32;

    // One extra pointer bit beyond the address separates full from empty.
    function automatic int calc_pw(input int len_log);
        return len_log + 1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/single_ch_dcfifo_n2p_ptr_sync_2ff.sv
// Two-stage pointer synchronizer with selectable clock edge, async reset
// and a synchronous clear.
module single_ch_dcfifo_n2p_ptr_sync_2ff #(
    parameter int W   = 3,
    parameter bit NEG = 1'b0
) (
    input  logic         CLK,
    input  logic         RST_X,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_d;
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_d;
    logic [W-1:0] s2_q;

    // Next-state of both stages, forced to zero by the clear input.
    always_comb begin
        s1_d = clr ? '0 : d;
        s2_d = clr ? '0 : s1_q;
    end

    generate
        if (NEG) begin : g_neg
            // Synchronizer stages clocked on the falling edge.
            always_ff @(negedge CLK or negedge RST_X) begin
                if (!RST_X) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                end
            end
        end else begin : g_pos
            // Synchronizer stages clocked on the rising edge.
            always_ff @(posedge CLK or negedge RST_X) begin
                if (!RST_X) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                end
            end
        end
    endgenerate

    assign q = s2_q;

endmodule

// File: rtl/single_ch_dcfifo_n2p.sv
// Register FIFO carrying one data channel from the CLK-negedge domain to a
// posedge valid/ready output register; Gray pointers cross via 2-FF syncs.
module single_ch_dcfifo_n2p
    import single_ch_dcfifo_n2p_pkg::*;
#(
    parameter int DW      = 27,
    parameter int LEN_LOG = 2
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          FRST,
    input  logic          wen,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          ovf,
    output logic [DW-1:0] dot,
    output logic          dvalid,
    input  logic          drdy
);

    localparam int PW = calc_pw(LEN_LOG);
    localparam int D  = 1 << LEN_LOG;
    // Gray full pattern: the two top bits of the read pointer are inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(2'b11) << (PW - 2);

    logic [DW-1:0] mem_d [D];
    logic [DW-1:0] mem_q [D];
    logic [PW-1:0] wbin_d, wbin_q, wgray_d, wgray_q;
    logic [PW-1:0] rbin_d, rbin_q, rgray_d, rgray_q;
    logic [PW-1:0] wsync_s, rsync_s;
    logic          fl_n_d, fl_n_q, ovf_d, ovf_q;
    logic [DW-1:0] dot_d, dot_q;
    logic          dvalid_d, dvalid_q;
    logic          full_s, wr_en_s, empty_s, pop_s;

    single_ch_dcfifo_n2p_ptr_sync_2ff #(.W(PW), .NEG(1'b0)) u_wsync (
        .CLK(CLK), .RST_X(RST_X), .clr(FRST), .d(wgray_q), .q(wsync_s)
    );

    single_ch_dcfifo_n2p_ptr_sync_2ff #(.W(PW), .NEG(1'b1)) u_rsync (
        .CLK(CLK), .RST_X(RST_X), .clr(fl_n_q), .d(rgray_q), .q(rsync_s)
    );

    // Write side: full/overflow flags, storage update and write pointer.
    always_comb begin
        full_s  = (wgray_q == (rsync_s ^ FULL_MASK)) | fl_n_q;
        wr_en_s = wen & ~full_s;
        fl_n_d  = FRST;
        mem_d   = mem_q;
        if (fl_n_q) begin
            wbin_d = '0;
            ovf_d  = 1'b0;
        end else begin
            ovf_d = ovf_q | (wen & full_s);
            if (wr_en_s) begin
                wbin_d = wbin_q + PW'(1'b1);
                mem_d[wbin_q[LEN_LOG-1:0]] = din;
            end else begin
                wbin_d = wbin_q;
            end
        end
        wgray_d = PW'(bin2gray(32'(wbin_d)));
    end

    // Write-domain state register.
    always_ff @(negedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mem_q   <= '{default: '0};
            wbin_q  <= '0;
            wgray_q <= '0;
            fl_n_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            fl_n_q  <= fl_n_d;
            ovf_q   <= ovf_d;
        end
    end

    // Read side: pop into the output register, drain it, or hold under backpressure.
    always_comb begin
        empty_s = (rgray_q == wsync_s);
        pop_s   = ~empty_s & (~dvalid_q | drdy);
        if (FRST) begin
            rbin_d   = '0;
            dot_d    = '0;
            dvalid_d = 1'b0;
        end else if (pop_s) begin
            rbin_d   = rbin_q + PW'(1'b1);
            dot_d    = mem_q[rbin_q[LEN_LOG-1:0]];
            dvalid_d = 1'b1;
        end else if (dvalid_q & drdy) begin
            rbin_d   = rbin_q;
            dot_d    = '0;
            dvalid_d = 1'b0;
        end else begin
            rbin_d   = rbin_q;
            dot_d    = dot_q;
            dvalid_d = dvalid_q;
        end
        rgray_d = PW'(bin2gray(32'(rbin_d)));
    end

    // Read-domain state register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            dot_q    <= '0;
            dvalid_q <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            dot_q    <= dot_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign full   = full_s;
    assign ovf    = ovf_q;
    assign dot    = dot_q;
    assign dvalid = dvalid_q;

endmodule

// File: tb/tb_single_ch_dcfifo_n2p.sv
// Scoreboard bench for single_ch_dcfifo_n2p: a queue of expected words is
// filled on accepted writes and drained by a monitor on consumer handshakes.
module tb_single_ch_dcfifo_n2p;

    localparam int DW = 27;

    logic          CLK;
    logic          RST_X;
    logic          FRST;
    logic          wen;
    logic [DW-1:0] din;
    logic          full;
    logic          ovf;
    logic [DW-1:0] dot;
    logic          dvalid;
    logic          drdy;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q [$];

    single_ch_dcfifo_n2p #(.DW(DW), .LEN_LOG(2)) dut (
        .CLK(CLK), .RST_X(RST_X), .FRST(FRST), .wen(wen), .din(din),
        .full(full), .ovf(ovf), .dot(dot), .dvalid(dvalid), .drdy(drdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One write on the next negedge; push marks it as expected to be accepted.
    task automatic wr(input logic [DW-1:0] d, input bit push);
        @(posedge CLK); #1;
        wen = 1'b1;
        din = d;
        @(negedge CLK); #1;
        wen = 1'b0;
        if (push) exp_q.push_back(d);
    endtask

    task automatic wait_dvalid();
        for (int i = 0; i < 30; i++) begin
            if (dvalid === 1'b1) break;
            @(negedge CLK);
        end
        chk("dvalid_wait", {31'd0, dvalid}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    // Write into an empty FIFO: visible after the third posedge, for one cycle.
    task automatic latency_check(input logic [DW-1:0] d);
        drdy = 1'b1;
        wr(d, 1'b1);
        @(negedge CLK);
        chk("lat_n1", {31'd0, dvalid}, 32'd0);
        @(negedge CLK);
        chk("lat_n2", {31'd0, dvalid}, 32'd0);
        @(negedge CLK);
        chk("lat_n3_valid", {31'd0, dvalid}, 32'd1);
        chk("lat_n3_data", {5'd0, dot}, {5'd0, d});
        @(negedge CLK);
        chk("lat_n4_valid", {31'd0, dvalid}, 32'd0);
        chk("lat_n4_dot", {5'd0, dot}, 32'd0);
    endtask

    // Monitor: consume on handshake, and dot must be zero whenever invalid.
    always @(negedge CLK) begin
        if (RST_X === 1'b1) begin
            if (dvalid === 1'b1 && drdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {5'd0, dot}, 32'hFFFFFFFF);
                end else begin
                    chk("data", {5'd0, dot}, {5'd0, exp_q.pop_front()});
                end
            end else if (dvalid !== 1'b1) begin
                chk("dot_zero", {5'd0, dot}, 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int iter;
        RST_X = 1'b0;
        FRST  = 1'b0;
        wen   = 1'b0;
        din   = '0;
        drdy  = 1'b0;
        #2;
        chk("rst_dot", {5'd0, dot}, 32'd0);
        chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        repeat (3) @(posedge CLK);
        #1 RST_X = 1'b1;

        // Single word.
        latency_check(27'h1234567);
        wait_drain();

        // Fill: one word parked in the output register, four in the array.
        drdy = 1'b0;
        wr(27'd0, 1'b1);
        wait_dvalid();
        repeat (4) @(posedge CLK);
        for (int i = 1; i <= 4; i++) begin
            wr(DW'(i), 1'b1);
            if (i == 3) chk("fill_not_full", {31'd0, full}, 32'd0);
        end
        @(posedge CLK); #1;
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_no_ovf", {31'd0, ovf}, 32'd0);
        wr(27'd5, 1'b0);
        @(posedge CLK); #1;
        chk("fill_ovf", {31'd0, ovf}, 32'd1);
        drdy = 1'b1;
        wait_drain();
        repeat (6) @(negedge CLK);

        // Backpressure hold, then flush with three words buffered.
        drdy = 1'b0;
        wr(27'h111, 1'b1);
        wr(27'h222, 1'b1);
        wr(27'h333, 1'b1);
        wait_dvalid();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("hold_dot", {5'd0, dot}, 32'h111);
            chk("hold_valid", {31'd0, dvalid}, 32'd1);
        end
        @(posedge CLK); #1;
        chk("pre_flush_ovf", {31'd0, ovf}, 32'd1);
        FRST = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        @(negedge CLK);
        chk("flush_dvalid", {31'd0, dvalid}, 32'd0);
        chk("flush_dot", {5'd0, dot}, 32'd0);
        @(posedge CLK); #1;
        chk("flush_full", {31'd0, full}, 32'd1);
        chk("flush_ovf", {31'd0, ovf}, 32'd0);
        @(posedge CLK);
        @(posedge CLK); #1;
        FRST = 1'b0;
        repeat (4) @(posedge CLK);
        #1 chk("post_flush_full", {31'd0, full}, 32'd0);
        drdy = 1'b1;
        wr(27'h2A, 1'b1);
        wait_dvalid();
        chk("flush_first_word", {5'd0, dot}, 32'h2A);
        wait_drain();

        // Wrap: 40 incrementing words, random write gaps and random drdy.
        sent = 0;
        iter = 0;
        while (sent < 40 && iter < 3000) begin
            @(posedge CLK); #1;
            drdy = 1'($urandom_range(0, 1));
            if (full === 1'b0 && $urandom_range(0, 3) != 0) begin
                wen = 1'b1;
                din = DW'(32'h100 + 32'(sent));
                exp_q.push_back(din);
                sent++;
            end else begin
                wen = 1'b0;
            end
            iter++;
        end
        @(posedge CLK); #1;
        wen = 1'b0;
        chk("wrap_sent", sent, 32'd40);
        drdy = 1'b1;
        wait_drain();
        chk("wrap_ovf", {31'd0, ovf}, 32'd0);

        // Asynchronous reset in the middle of traffic.
        drdy = 1'b0;
        for (int i = 0; i < 8; i++) wr(DW'(32'h500 + 32'(i)), 1'b0);
        repeat (6) @(posedge CLK);
        #1;
        chk("pre_rst_full", {31'd0, full}, 32'd1);
        chk("pre_rst_ovf", {31'd0, ovf}, 32'd1);
        chk("pre_rst_valid", {31'd0, dvalid}, 32'd1);
        #2 RST_X = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_dot", {5'd0, dot}, 32'd0);
        chk("arst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("arst_full", {31'd0, full}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST_X = 1'b1;
        latency_check(27'h7654321);
        wait_drain();

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
